// File: rtl/gate_tt_sweeper.sv
// Self-checking harness for a 2-input gate: sweeps all four input combos,
// samples the gate output after a settle interval and scores it against a truth table.
module gate_tt_sweeper #(
  parameter logic [3:0]  EXPECTED_TT   = 4'b1001,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       out1,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [9:0] PASS_LAST   = 10'(NUM_PASSES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state, state_d;
  logic [1:0] idx, idx_d;
  logic [7:0] settle_cnt, settle_cnt_d;
  logic [9:0] pass_cnt, pass_cnt_d;
  logic       in1_d, in2_d, busy_d, done_d, pass_d;
  logic [7:0] err_cnt_d;
  logic [3:0] fail_vec_d;
  logic       mismatch;

  assign mismatch = (out1 != EXPECTED_TT[idx]);

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    settle_cnt_d = settle_cnt;
    pass_cnt_d   = pass_cnt;
    in1_d        = in1;
    in2_d        = in2;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    err_cnt_d    = err_cnt;
    fail_vec_d   = fail_vec;
    unique case (state)
      IDLE: begin
        if (start) begin
          err_cnt_d    = 8'd0;
          fail_vec_d   = 4'd0;
          pass_d       = 1'b0;
          idx_d        = 2'd0;
          pass_cnt_d   = 10'd0;
          settle_cnt_d = 8'd0;
          in1_d        = 1'b0;
          in2_d        = 1'b0;
          busy_d       = 1'b1;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_d = 8'd0;
          state_d      = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt + 8'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_cnt_d       = sat_inc(err_cnt);
          fail_vec_d[idx] = 1'b1;
        end
        if (idx != 2'd3) begin
          idx_d          = idx + 2'd1;
          {in1_d, in2_d} = idx + 2'd1;
          state_d        = SETTLE;
        end else if (pass_cnt != PASS_LAST) begin
          idx_d          = 2'd0;
          {in1_d, in2_d} = 2'd0;
          pass_cnt_d     = pass_cnt + 10'd1;
          state_d        = SETTLE;
        end else begin
          // Verdict uses the count including this final sample.
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 8'd0);
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 8'd0;
      pass_cnt   <= 10'd0;
      in1        <= 1'b0;
      in2        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 8'd0;
      fail_vec   <= 4'd0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      settle_cnt <= settle_cnt_d;
      pass_cnt   <= pass_cnt_d;
      in1        <= in1_d;
      in2        <= in2_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_cnt    <= err_cnt_d;
      fail_vec   <= fail_vec_d;
    end
  end

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// Bench for gate_tt_sweeper: random truth-table gates scored against a
// closed-form model of the sweep timing, verdict, error count and fail flags.
module tb_gate_tt_sweeper;

  localparam logic [3:0] EXP_TT = 4'b1001;
  localparam int S    = 2;
  localparam int NP_B = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [3:0] gate_tt = EXP_TT;

  logic       out1_a, in1_a, in2_a, busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic [3:0] fail_a;
  logic       out1_b, in1_b, in2_b, busy_b, done_b, pass_b;
  logic [7:0] err_b;
  logic [3:0] fail_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Gate under test: arbitrary truth table for A, an inverted XNOR for B.
  assign out1_a = gate_tt[{in1_a, in2_a}];
  assign out1_b = ~EXP_TT[{in1_b, in2_b}];

  gate_tt_sweeper #(.EXPECTED_TT(EXP_TT), .SETTLE_CYCLES(S), .NUM_PASSES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .out1(out1_a),
    .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .fail_vec(fail_a));

  gate_tt_sweeper #(.EXPECTED_TT(EXP_TT), .SETTLE_CYCLES(S), .NUM_PASSES(NP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .out1(out1_b),
    .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .fail_vec(fail_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int popcnt4(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  // One single-pass sweep on A; cycle 0 is the cycle start is high.
  task automatic sweep_a(input logic [3:0] tt, input bit repulse);
    int lat;
    int exp_err;
    int dones;
    logic [3:0] exp_fail;
    lat      = 4 * (S + 1) + 1;
    exp_fail = tt ^ EXP_TT;
    exp_err  = popcnt4(exp_fail);
    dones    = 0;
    gate_tt  = tt;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      start_a = repulse && (c == 3 || c == 12);
      if (done_a) dones++;
      chk("busy", busy_a, c <= lat);
      chk("done", done_a, c == lat);
      chk("combo", {in1_a, in2_a}, (c < lat) ? ((c - 1) / (S + 1)) % 4 : 3);
      if (c >= lat) begin
        chk("err_cnt", err_a, exp_err);
        chk("fail_vec", fail_a, exp_fail);
        chk("pass", pass_a, exp_err == 0);
      end
    end
    start_a = 1'b0;
    chk("done_count", dones, 1);
  endtask

  initial begin
    int cyc;

    repeat (3) @(negedge clk);
    chk("rst_in1", in1_a, 0);
    chk("rst_in2", in2_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fail", fail_a, 0);
    chk("rst_b_err", err_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep_a(EXP_TT, 1'b0);   // correct XNOR
    sweep_a(4'b1000, 1'b0);  // AND gate
    sweep_a(4'b0000, 1'b0);  // stuck at 0
    sweep_a(EXP_TT, 1'b0);   // results cleared by new start
    sweep_a(EXP_TT, 1'b1);   // start re-pulsed while busy

    // Reset mid-sweep at cycle 7 with a stuck-0 gate.
    gate_tt = 4'b0000;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("pre_rst_err", err_a, 1);
    chk("pre_rst_busy", busy_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_err", err_a, 0);
    chk("mid_rst_fail", fail_a, 0);
    chk("mid_rst_in", {in1_a, in2_a}, 0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("post_rst_idle_done", done_a, 0);
      chk("post_rst_idle_busy", busy_a, 0);
    end
    sweep_a(EXP_TT, 1'b0);

    // start held high: re-accepted on the IDLE cycle right after DONE.
    gate_tt = EXP_TT;
    @(negedge clk);
    start_a = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 13) chk("held_done", done_a, 1);
      if (c == 14) chk("held_idle_busy", busy_a, 0);
      if (c == 15) begin
        chk("held_reaccept_busy", busy_a, 1);
        chk("held_reaccept_combo", {in1_a, in2_a}, 0);
      end
    end
    start_a = 1'b0;
    cyc = 15;
    while (!done_a && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_second_done_cycle", cyc, 27);
    @(negedge clk);
    chk("held_after_busy", busy_a, 0);

    for (int k = 0; k < 10; k++) sweep_a(4'($urandom), 1'($urandom));

    // Multi-pass run with an inverted gate: count saturates at 255.
    @(negedge clk);
    start_b = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start_b = 1'b0;
      cyc++;
    end while (!done_b && cyc < 2000);
    chk("b_done_cycle", cyc, 4 * NP_B * (S + 1) + 1);
    chk("b_err_sat", err_b, (4 * NP_B > 255) ? 255 : 4 * NP_B);
    chk("b_fail_vec", fail_b, 4'hF);
    chk("b_pass", pass_b, 0);
    chk("b_busy", busy_b, 1);
    repeat (3) @(negedge clk);
    chk("b_err_hold", err_b, 255);
    chk("b_fail_hold", fail_b, 4'hF);
    chk("b_idle_busy", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/gate_tt_sweeper.md
Name: gate_tt_sweeper

Overview:
- Sequential stimulus and check stage wrapped around a 2-input gate under test, such as xnor_gate.
- Drives in1/in2 through all four input combinations and samples the gate's out1 after a settle interval.
- Compares each sample against a parameterised expected truth table and reports pass/fail, a mismatch count and the failing combinations.
- Feeds the gate's inputs (upstream) and consumes its output (downstream) within one self-checking harness block.

Parameters:
- EXPECTED_TT, 4'b1001, expected out1 indexed by {in1,in2}; bit0 is combo 00 and bit3 is combo 11. The default is the XNOR truth table.
- SETTLE_CYCLES, 2, cycles each combo is held before sampling; legal range 1..255.
- NUM_PASSES, 1, full 4-combo sweeps per start; legal range 1..1023.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- out1  input  1  output of the gate under test.
- in1  output  1  drive to the gate's in1 (MSB of the combo index).
- in2  output  1  drive to the gate's in2 (LSB of the combo index).
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_cnt  output  8  saturating mismatch count for the current/last run.
- fail_vec  output  4  sticky per-combo mismatch flags, bit index = {in1,in2}.

Behaviour:
- Reset:
  - Reset is synchronous and active-low: rst_n low at a rising clk edge resets the block.
  - All outputs are registered and reset to 0.
  - State returns to IDLE; combo index, settle counter and pass counter clear to 0.
  - Reset mid-sweep aborts immediately. No done pulse is issued, and results are cleared, not retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at a clock edge is accepted: err_cnt, fail_vec and pass clear, idx=0, pass_cnt=0.
  - Next state is SETTLE, with in1/in2 = 0/0 and busy=1.
  - In IDLE, in1/in2 hold their last driven values.
- SETTLE:
  - Holds in1/in2 = idx[1:0] for SETTLE_CYCLES cycles, counting 0..SETTLE_CYCLES-1, then moves to SAMPLE.
- SAMPLE (one cycle):
  - Compares out1 with EXPECTED_TT[idx].
  - On mismatch: err_cnt increments, saturating at 255, and fail_vec[idx] is set.
  - Same edge, if idx<3: idx increments, in1/in2 update to the new idx, go to SETTLE.
  - Same edge, if idx==3 and pass_cnt<NUM_PASSES-1: idx wraps to 0, pass_cnt increments, go to SETTLE.
  - Otherwise: go to DONE.
- DONE (one cycle):
  - done=1, busy=1.
  - pass is registered as (err_cnt==0), using err_cnt including the final sample's update.
  - Next state is IDLE with busy=0.
  - pass, err_cnt and fail_vec hold until the next accepted start or reset.
- Latency:
  - Each combo takes SETTLE_CYCLES+1 cycles.
  - done asserts 4*NUM_PASSES*(SETTLE_CYCLES+1)+1 cycles after the start edge (13 with defaults).
- start while busy (SETTLE/SAMPLE/DONE) is ignored; it is not queued.
- start held high continuously: a new sweep is accepted on the IDLE cycle right after DONE.
- Simultaneous rst_n=0 and start=1: reset wins.
- err_cnt saturation: at 255, further mismatches leave err_cnt at 255, but fail_vec still updates.
- The out1 sample is the value present at the SAMPLE-cycle clock edge. No combinational path exists from out1 to any output.

Test Plan:
- Correct XNOR model, defaults, start pulse at cycle 0 -> in1/in2 sequence 00,01,10,11 for 3 cycles each; done at cycle 13; pass=1, err_cnt=0, fail_vec=0000.
- AND gate substituted as DUT -> combo 00 mismatches; err_cnt=1, fail_vec=0001, pass=0.
- out1 stuck at 0 -> mismatches at 00 and 11; err_cnt=2, fail_vec=1001, pass=0. Then a second start with a good XNOR -> results cleared, pass=1, err_cnt=0.
- start re-pulsed at cycles 3 and 12 during a sweep -> ignored: exactly one done at cycle 13; next sweep accepted only from IDLE.
- rst_n low at cycle 7 mid-sweep -> on the next edge all outputs are 0, state IDLE, no done pulse. A later start sweeps normally.
- NUM_PASSES=64 with an inverted DUT (4 mismatches per pass) -> err_cnt saturates at 255 and holds; fail_vec=1111; done at 4*64*3+1=769 cycles after start.
